i2c_poll_sequencer: RTL
=======================

// Module: i2c_poll_sequencer
// PURPOSE
//  Upstream command stage for the i2c master (enable=1 instance, DATA_BYTES=2).
//  Sweeps a fixed list of NUM_REGS register addresses on one chip, issuing one
//  16-bit read per entry through the master's read_en/busy/done handshake.
//  Stores each result in a local shadow bank readable by the host, then repeats
//  the sweep after a programmable idle period.
// PARAMETERS
//  NUM_REGS   4     entries per sweep, >=2; IDX_W = $clog2(NUM_REGS)
//  TIMEOUT    4096  max clk cycles in WAIT_BUSY or WAIT_DONE before the entry is abandoned
// PORTS
//  clk          in   1            system clock (same clock as the i2c master)
//  reset        in   1            asynchronous, active-high
//  enable       in   1            level: run continuous sweeps
//  one_shot     in   1            pulse in IDLE: run exactly one sweep
//  chip_addr    in   7            target 7-bit chip address, sampled at sweep start
//  reg_list     in   NUM_REGS*8   entry i = reg_list[8*i+7:8*i], sampled per entry at ISSUE
//  period       in   16           idle clk cycles between sweeps
//  clr_err      in   1            pulse: clear err_count and err_flag
//  m_chip_addr  out  7            to master chip_addr
//  m_reg_addr   out  8            to master reg_addr
//  m_read_en    out  1            to master read_en
//  m_busy       in   1            from master busy
//  m_done       in   1            from master done (1-cycle pulse)
//  m_status     in   4            from master status; nonzero at m_done = failed transfer
//  m_data_out   in   16           from master data_out0; valid in the m_done cycle
//  rd_idx       in   IDX_W        host read index
//  rd_data      out  16           shadow[rd_idx], combinational
//  rd_valid     out  1            valid[rd_idx], combinational
//  sweep_done   out  1            1-cycle pulse after the last entry of a sweep is processed
//  err_flag     out  1            sticky: any failed or timed-out entry since last clr_err
//  err_count    out  8            saturating (at 255) count of failed/timed-out entries
//  active       out  1            high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; shadow regs 0; valid bits 0; FSM goes to IDLE; idx 0.
//  FSM states:
//   IDLE: enable|one_shot -> latch chip_addr, latch mode (continuous if enable);
//    idx=0 -> ISSUE.
//   ISSUE: drive m_reg_addr=reg_list[idx], m_read_en=1; clear tmo counter -> WAIT_BUSY.
//   WAIT_BUSY: hold m_read_en=1 until m_busy=1, then drop m_read_en next cycle
//    -> WAIT_DONE. An m_done in the same cycle as m_busy is handled as in WAIT_DONE.
//   WAIT_DONE: on m_done: if m_status==0, shadow[idx]<=m_data_out and valid[idx]<=1;
//    else valid[idx]<=0 and it counts as an error -> NEXT.
//   NEXT: idx==NUM_REGS-1 -> pulse sweep_done; idx<=0 -> WAIT_PERIOD (continuous)
//    or IDLE (one_shot). Otherwise idx<=idx+1 -> ISSUE.
//   WAIT_PERIOD: count period cycles (period=0 -> leave next cycle) -> ISSUE if
//    enable=1, else IDLE.
//  Timeout: tmo counter counts cycles in WAIT_BUSY+WAIT_DONE. Reaching TIMEOUT means
//   error: valid[idx]<=0, m_read_en<=0 -> NEXT. A late m_done is ignored.
//  Latency: m_read_en asserts 1 cycle after the start trigger; shadow/valid update
//   1 cycle after the m_done cycle; sweep_done 1 cycle after the last update.
//  enable drop mid-sweep: the current transfer completes and is stored; the sweep
//   stops at NEXT -> IDLE (no sweep_done if the sweep is incomplete).
//  one_shot outside IDLE: ignored. enable and one_shot together: continuous.
//  Errors: err_flag<=1; err_count saturates at 255. clr_err in the same cycle as an
//   error: clear first, then count the error (err_count=1, err_flag=1).
//  m_chip_addr is held constant for a whole sweep. m_reg_addr is held from ISSUE
//   until leaving WAIT_DONE.
//  Reset asserted mid-transfer: immediate return to IDLE with m_read_en=0; master
//   recovery is the master's responsibility.
// TESTING
//  Slave model 0x0F with regs {00:A1A1,01:B2B2,02:C3C3,03:D4D4}; one_shot,
//   reg_list={03,02,01,00} -> shadow[0..3] match, all valid, one sweep_done, err_count=0.
//  enable=1, period=100 -> successive m_read_en rises within a sweep; sweep_done
//   pulses spaced by one sweep time + 100 cycles; data is stable.
//  chip_addr=0x22 (NACK, status!=0) -> valid=0 for all, err_count=4, err_flag=1;
//   clr_err -> 0.
//  Master model holds m_busy low -> each entry times out after 4096 cycles, m_read_en
//   drops, err_count increments per entry; continuous mode ends up saturating at 255.
//  Drop enable during entry 1 -> entry 1 is stored; IDLE; no sweep_done; active=0.
//  Assert reset during WAIT_DONE -> all outputs 0 in the same cycle; a new one_shot
//   after release runs cleanly.

Source files
------------

// File: rtl/i2c_poll_sequencer.sv
// Command sequencer in front of an i2c master: sweeps a fixed register list on one chip,
// issuing 16-bit reads and keeping the results in a host-readable shadow bank.
module i2c_poll_sequencer #(
    parameter int NUM_REGS = 4,
    parameter int TIMEOUT  = 4096,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  one_shot,
    input  logic [6:0]            chip_addr,
    input  logic [NUM_REGS*8-1:0] reg_list,
    input  logic [15:0]           period,
    input  logic                  clr_err,
    output logic [6:0]            m_chip_addr,
    output logic [7:0]            m_reg_addr,
    output logic                  m_read_en,
    input  logic                  m_busy,
    input  logic                  m_done,
    input  logic [3:0]            m_status,
    input  logic [15:0]           m_data_out,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    output logic                  sweep_done,
    output logic                  err_flag,
    output logic [7:0]            err_count,
    output logic                  active
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_NEXT, S_WAIT_PERIOD
    } state_t;

    state_t                    state, state_nx;
    logic [IDX_W-1:0]          idx;
    logic                      continuous;
    logic [TMO_W-1:0]          tmo_cnt;
    logic [15:0]               per_cnt;
    logic [7:0]                reg_addr_q;
    logic [NUM_REGS-1:0][15:0] shadow;
    logic [NUM_REGS-1:0]       valid;

    logic take_done, tmo_hit, entry_err, per_end, last;

    always_comb begin
        take_done = (state == S_WAIT_DONE && m_done) ||
                    (state == S_WAIT_BUSY && m_busy && m_done);
        // done beats a timeout landing in the same cycle
        tmo_hit   = (state == S_WAIT_BUSY || state == S_WAIT_DONE) && !take_done &&
                    (tmo_cnt == TMO_LAST);
        entry_err = (take_done && m_status != 4'd0) || tmo_hit;
        per_end   = ({1'b0, per_cnt} + 17'd1) >= {1'b0, period};
        last      = (idx == LAST_IDX);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:        if (enable || one_shot) state_nx = S_ISSUE;
            S_ISSUE:       state_nx = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (take_done || tmo_hit) state_nx = S_NEXT;
                else if (m_busy)          state_nx = S_WAIT_DONE;
            end
            S_WAIT_DONE:   if (take_done || tmo_hit) state_nx = S_NEXT;
            S_NEXT: begin
                if (continuous && !enable) state_nx = S_IDLE;
                else if (last)             state_nx = continuous ? S_WAIT_PERIOD : S_IDLE;
                else                       state_nx = S_ISSUE;
            end
            S_WAIT_PERIOD: if (per_end) state_nx = enable ? S_ISSUE : S_IDLE;
            default:       state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx         <= '0;
            continuous  <= 1'b0;
            tmo_cnt     <= '0;
            per_cnt     <= '0;
            reg_addr_q  <= '0;
            m_chip_addr <= '0;
            shadow      <= '0;
            valid       <= '0;
            sweep_done  <= 1'b0;
        end else begin
            sweep_done <= (state == S_NEXT) && last;
            case (state)
                S_IDLE: if (enable || one_shot) begin
                    m_chip_addr <= chip_addr;
                    continuous  <= enable;
                    idx         <= '0;
                end
                S_ISSUE: begin
                    reg_addr_q <= reg_list[{idx, 3'b000} +: 8];
                    tmo_cnt    <= '0;
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    if (take_done) begin
                        valid[idx] <= (m_status == 4'd0);
                        if (m_status == 4'd0) shadow[idx] <= m_data_out;
                    end else if (tmo_hit) begin
                        valid[idx] <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    idx     <= last ? '0 : idx + 1'b1;
                    per_cnt <= '0;
                end
                S_WAIT_PERIOD: if (!per_end) per_cnt <= per_cnt + 16'd1;
                default: ;
            endcase
        end
    end

    // A clear in the same cycle as an error wins first, then the error is counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flag  <= 1'b0;
            err_count <= 8'd0;
        end else if (clr_err) begin
            err_flag  <= entry_err;
            err_count <= entry_err ? 8'd1 : 8'd0;
        end else if (entry_err) begin
            err_flag <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    assign m_read_en  = (state == S_ISSUE) || (state == S_WAIT_BUSY);
    assign m_reg_addr = (state == S_ISSUE) ? reg_list[{idx, 3'b000} +: 8] : reg_addr_q;
    assign active     = (state != S_IDLE);

    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        if (int'(rd_idx) < NUM_REGS) begin
            rd_data  = shadow[rd_idx];
            rd_valid = valid[rd_idx];
        end
    end
endmodule
